pvr_vram_arb: RTL and testbench

PVR_VRAM_ARB -- requirements
Module: pvr_vram_arb

---
 rtl/pvr_vram_arb.sv | 181 ++++++++++++++++++
 tb/tb_pvr_vram_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pvr_vram_arb.sv
// pvr_vram_arb: arbitrates one VRAM port between three requesters
// (bit0 ISP parser, bit1 TSP param fetch, bit2 texture fetch).
// Only one VRAM transaction is ever outstanding.
// A write owner holding req_lock keeps the port for up to BURST_MAX beats.
// Optional macro PVR_VRAM_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority.
// With that macro, bit0 has the highest priority and bit2 the lowest.
module pvr_vram_arb #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          req_rd,
  input  logic [2:0]          req_wr,
  input  logic [2:0]          req_lock,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_wdata,
  output logic [2:0]          req_ack,
  output logic [2:0]          req_rvalid,
  output logic [DATA_W-1:0]   req_rdata,
  output logic                vram_rd,
  output logic                vram_wr,
  output logic [ADDR_W-1:0]   vram_addr,
  output logic [DATA_W-1:0]   vram_wdata,
  input  logic                vram_ack,
  input  logic                vram_rvalid,
  input  logic [DATA_W-1:0]   vram_rdata,
  output logic [1:0]          grant_id,
  output logic                busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CMD    = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BEAT_LIMIT = BW'(BURST_MAX);

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BW-1:0]     beats_q, beats_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [2:0]    req_any;
  logic [1:0]    win_id;
  logic [2:0]    win_onehot;
  logic [2:0]    owner_onehot;
  logic          lock_own;
  logic          own_req;
  logic [BW-1:0] beats_inc;

  assign req_any      = req_rd | req_wr;
  assign win_onehot   = 3'b001 << win_id;
  assign owner_onehot = 3'b001 << owner_q;
  assign lock_own     = |(req_lock & owner_onehot);
  assign own_req      = |(req_any & owner_onehot);
  assign beats_inc    = beats_q + BW'(1);

`ifdef PVR_VRAM_ARB_FIXED_PRIO_EN
  // Fixed priority pick: the ISP parser always wins, texture fetch loses
  always_comb begin
    if (req_any[0])      win_id = 2'd0;
    else if (req_any[1]) win_id = 2'd1;
    else                 win_id = 2'd2;
  end
`else
  logic [1:0] last_owner_q, last_owner_d;

  // Round-robin pick: the search starts one past the last released owner
  always_comb begin
    win_id = 2'd0;
    case (last_owner_q)
      2'd0:    win_id = req_any[1] ? 2'd1 : (req_any[2] ? 2'd2 : 2'd0);
      2'd1:    win_id = req_any[2] ? 2'd2 : (req_any[0] ? 2'd0 : 2'd1);
      default: win_id = req_any[0] ? 2'd0 : (req_any[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Record the owner only when the grant actually drops back to IDLE
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q != ST_IDLE && state_d == ST_IDLE) last_owner_d = owner_q;
  end

  // Reset value 2 makes requester 0 the first round-robin winner
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_owner_q <= 2'd2;
    else       last_owner_q <= last_owner_d;
  end
`endif

  // Next state: latch the command, track beats, and decide where to go next
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    is_rd_d  = is_rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    beats_d  = beats_q;
    rvalid_d = 3'b000;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_any) begin
          owner_d = win_id;
          is_rd_d = |(req_rd & win_onehot);
          addr_d  = req_addr[win_id*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[win_id*DATA_W +: DATA_W];
          beats_d = '0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (vram_ack) begin
          beats_d = beats_inc;
          if (is_rd_q)                              state_d = ST_RDWAIT;
          else if (lock_own && beats_inc < BEAT_LIMIT) state_d = ST_LOCKED;
          else                                      state_d = ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        if (vram_rvalid) begin
          rdata_d  = vram_rdata;
          rvalid_d = owner_onehot;
          if (lock_own && beats_q < BEAT_LIMIT) state_d = ST_LOCKED;
          else                                  state_d = ST_IDLE;
        end
      end
      default: begin
        if (own_req) begin
          is_rd_d = |(req_rd & owner_onehot);
          addr_d  = req_addr[owner_q*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[owner_q*DATA_W +: DATA_W];
          state_d = ST_CMD;
        end else if (!lock_own) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 2'd0;
      is_rd_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      beats_q  <= '0;
      rvalid_q <= 3'b000;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      is_rd_q  <= is_rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      beats_q  <= beats_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign vram_rd    = (state_q == ST_CMD) && is_rd_q;
  assign vram_wr    = (state_q == ST_CMD) && !is_rd_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign req_ack    = (state_q == ST_CMD && vram_ack) ? owner_onehot : 3'b000;
  assign req_rvalid = rvalid_q;
  assign req_rdata  = rdata_q;
  assign grant_id   = (state_q == ST_IDLE) ? 2'd3 : owner_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pvr_vram_arb.sv
// tb_pvr_vram_arb: vector table for single transactions, plus hand sequences for
// round-robin order, locked bursts, a withheld ack, and reset during a read.
module tb_pvr_vram_arb;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam logic [AW-1:0] A0 = 24'h0129F8;
  localparam logic [AW-1:0] A1 = 24'h000100;
  localparam logic [AW-1:0] A2 = 24'h000200;
  localparam logic [DW-1:0] W0 = 32'h00000A0A;
  localparam logic [DW-1:0] W1 = 32'h11110B0B;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    req_rd = 3'b000;
  logic [2:0]    req_wr = 3'b000;
  logic [2:0]    req_lock = 3'b000;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]    req_ack;
  logic [2:0]    req_rvalid;
  logic [DW-1:0] req_rdata;
  logic          vram_rd;
  logic          vram_wr;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata;
  logic          vram_ack = 1'b0;
  logic          vram_rvalid = 1'b0;
  logic [DW-1:0] vram_rdata = '0;
  logic [1:0]    grant_id;
  logic          busy;

  int assert_count = 0;
  int fail_count = 0;

  pvr_vram_arb #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(16)) dut (
    .clock(clock), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_ack(vram_ack), .vram_rvalid(vram_rvalid), .vram_rdata(vram_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]    rd;
    logic [2:0]    wr;
    logic [2:0]    lock;
    logic          vack;
    logic          vrv;
    logic [DW-1:0] vrdata;
    logic [2:0]    e_ack;
    logic [2:0]    e_rv;
    logic          e_vrd;
    logic          e_vwr;
    logic [1:0]    e_gid;
    logic          e_busy;
    logic [DW-1:0] e_rdata;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs [21];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_rd      = v.rd;
    req_wr      = v.wr;
    req_lock    = v.lock;
    vram_ack    = v.vack;
    vram_rvalid = v.vrv;
    vram_rdata  = v.vrdata;
  endtask

  task automatic resetDut();
    req_rd = 3'b000; req_wr = 3'b000; req_lock = 3'b000;
    vram_ack = 1'b0; vram_rvalid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic waitCmd(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clock);
      #1;
      if (vram_rd || vram_wr) seen = 1'b1;
    end
  endtask

  // Plays the VRAM side for one command; returns at a negedge after the ack
  task automatic serveOne(output logic [1:0] gid, output logic [DW-1:0] wdata, output bit seen);
    logic was_read;
    waitCmd(seen);
    gid = grant_id;
    wdata = vram_wdata;
    was_read = vram_rd;
    if (seen) begin
      vram_ack = 1'b1;
      @(negedge clock);
      vram_ack = 1'b0;
      if (was_read) begin
        vram_rvalid = 1'b1;
        vram_rdata = 32'h5A5A0000;
        @(negedge clock);
        vram_rvalid = 1'b0;
      end
    end
  endtask

  // Hard stop in case some wait never returns
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] gid;
    logic [DW-1:0] wd;
    bit seen;
    int beats2;
    logic [1:0] exp_rr [6];
    logic [1:0] exp_gid;
    logic [DW-1:0] exp_wd;

    req_addr  = {A2, A1, A0};
    req_wdata = {32'h0, W1, W0};

    vecs[0]  = '{3'b000,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b000,1'b0,1'b0,2'd3,1'b0,32'h0,        24'h0};
    vecs[1]  = '{3'b001,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b000,1'b0,1'b0,2'd3,1'b0,32'h0,        24'h0};
    vecs[2]  = '{3'b001,3'b000,3'b000,1'b1,1'b0,32'h0,        3'b001,3'b000,1'b1,1'b0,2'd0,1'b1,32'h0,        A0};
    vecs[3]  = '{3'b000,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b000,1'b0,1'b0,2'd0,1'b1,32'h0,        A0};
    vecs[4]  = '{3'b000,3'b000,3'b000,1'b0,1'b1,32'hDEADBEEF, 3'b000,3'b000,1'b0,1'b0,2'd0,1'b1,32'h0,        A0};
    vecs[5]  = '{3'b000,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b001,1'b0,1'b0,2'd3,1'b0,32'hDEADBEEF, A0};
    vecs[6]  = '{3'b000,3'b000,3'b000,1'b1,1'b1,32'hCAFEF00D, 3'b000,3'b000,1'b0,1'b0,2'd3,1'b0,32'hDEADBEEF, A0};
    vecs[7]  = '{3'b000,3'b010,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b000,1'b0,1'b0,2'd3,1'b0,32'hDEADBEEF, A0};
    vecs[8]  = '{3'b000,3'b010,3'b000,1'b1,1'b0,32'h0,        3'b010,3'b000,1'b0,1'b1,2'd1,1'b1,32'hDEADBEEF, A1};
    vecs[9]  = '{3'b000,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b000,1'b0,1'b0,2'd3,1'b0,32'hDEADBEEF, A1};
    vecs[10] = '{3'b100,3'b100,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b000,1'b0,1'b0,2'd3,1'b0,32'hDEADBEEF, A1};
    vecs[11] = '{3'b100,3'b100,3'b000,1'b1,1'b0,32'h0,        3'b100,3'b000,1'b1,1'b0,2'd2,1'b1,32'hDEADBEEF, A2};
    vecs[12] = '{3'b000,3'b000,3'b000,1'b0,1'b1,32'h12345678, 3'b000,3'b000,1'b0,1'b0,2'd2,1'b1,32'hDEADBEEF, A2};
    vecs[13] = '{3'b000,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b100,1'b0,1'b0,2'd3,1'b0,32'h12345678, A2};
    vecs[14] = '{3'b011,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b000,1'b0,1'b0,2'd3,1'b0,32'h12345678, A2};
    vecs[15] = '{3'b011,3'b000,3'b000,1'b1,1'b0,32'h0,        3'b001,3'b000,1'b1,1'b0,2'd0,1'b1,32'h12345678, A0};
    vecs[16] = '{3'b010,3'b000,3'b000,1'b0,1'b1,32'h00000001, 3'b000,3'b000,1'b0,1'b0,2'd0,1'b1,32'h12345678, A0};
    vecs[17] = '{3'b010,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b001,1'b0,1'b0,2'd3,1'b0,32'h00000001, A0};
    vecs[18] = '{3'b010,3'b000,3'b000,1'b1,1'b0,32'h0,        3'b010,3'b000,1'b1,1'b0,2'd1,1'b1,32'h00000001, A1};
    vecs[19] = '{3'b000,3'b000,3'b000,1'b0,1'b1,32'h00000002, 3'b000,3'b000,1'b0,1'b0,2'd1,1'b1,32'h00000001, A1};
    vecs[20] = '{3'b000,3'b000,3'b000,1'b0,1'b0,32'h0,        3'b000,3'b010,1'b0,1'b0,2'd3,1'b0,32'h00000002, A1};

`ifdef PVR_VRAM_ARB_FIXED_PRIO_EN
    exp_rr = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_rr = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`endif

    $display("[TB] starting");
    resetDut();

    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d req_ack", i),    32'(req_ack),    32'(vecs[i].e_ack));
      checkOutput($sformatf("v%0d req_rvalid", i), 32'(req_rvalid), 32'(vecs[i].e_rv));
      checkOutput($sformatf("v%0d vram_rd", i),    32'(vram_rd),    32'(vecs[i].e_vrd));
      checkOutput($sformatf("v%0d vram_wr", i),    32'(vram_wr),    32'(vecs[i].e_vwr));
      checkOutput($sformatf("v%0d grant_id", i),   32'(grant_id),   32'(vecs[i].e_gid));
      checkOutput($sformatf("v%0d busy", i),       32'(busy),       32'(vecs[i].e_busy));
      checkOutput($sformatf("v%0d req_rdata", i),  req_rdata,       vecs[i].e_rdata);
      checkOutput($sformatf("v%0d vram_addr", i),  32'(vram_addr),  32'(vecs[i].e_addr));
      if (i == 8) checkOutput("v8 vram_wdata", vram_wdata, W1);
    end

    // All three readers held continuously
    resetDut();
    req_rd = 3'b111;
    for (int g = 0; g < 6; g++) begin
      serveOne(gid, wd, seen);
      checkOutput($sformatf("rr%0d seen", g), 32'(seen), 32'd1);
      checkOutput($sformatf("rr%0d grant", g), 32'(gid), 32'(exp_rr[g]));
    end
    req_rd = 3'b000;

    // Locked write burst from texture fetch with the ISP parser waiting
    resetDut();
    req_wdata[2*DW +: DW] = 32'd0;
    req_wr = 3'b100;
    req_lock = 3'b100;
    beats2 = 0;
    for (int g = 0; g < 21; g++) begin
      serveOne(gid, wd, seen);
      exp_gid = (g == 16) ? 2'd0 : 2'd2;
      exp_wd  = (g < 16) ? 32'(g) : ((g == 16) ? W0 : 32'(g - 1));
      checkOutput($sformatf("burst%0d grant", g), 32'(gid), 32'(exp_gid));
      checkOutput($sformatf("burst%0d wdata", g), wd, exp_wd);
      if (gid == 2'd2) begin
        beats2++;
        req_wdata[2*DW +: DW] = 32'(beats2);
        if (beats2 == 20) begin
          req_wr[2] = 1'b0;
          req_lock[2] = 1'b0;
        end
      end
      if (gid == 2'd0) req_wr[0] = 1'b0;
      if (g == 0) req_wr[0] = 1'b1;
    end
    @(negedge clock);
    #1;
    checkOutput("burst end grant_id", 32'(grant_id), 32'd3);
    checkOutput("burst end busy", 32'(busy), 32'd0);

    // Ack withheld for ten cycles while in CMD
    resetDut();
    req_rd = 3'b010;
    waitCmd(seen);
    checkOutput("hold cmd seen", 32'(seen), 32'd1);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("hold%0d vram_rd", k), 32'(vram_rd), 32'd1);
      checkOutput($sformatf("hold%0d vram_addr", k), 32'(vram_addr), 32'(A1));
      checkOutput($sformatf("hold%0d req_ack", k), 32'(req_ack), 32'd0);
      @(negedge clock);
      #1;
    end
    vram_ack = 1'b1;
    #1;
    checkOutput("hold ack pulse", 32'(req_ack), 32'b010);
    @(negedge clock);
    vram_ack = 1'b0;
    req_rd = 3'b000;
    #1;
    checkOutput("hold after ack req_ack", 32'(req_ack), 32'd0);
    checkOutput("hold after ack vram_rd", 32'(vram_rd), 32'd0);
    vram_rvalid = 1'b1;
    vram_rdata = 32'h0BADF00D;
    @(negedge clock);
    vram_rvalid = 1'b0;
    #1;
    checkOutput("hold rvalid", 32'(req_rvalid), 32'b010);
    checkOutput("hold rdata", req_rdata, 32'h0BADF00D);

    // Reset while waiting for read data
    resetDut();
    req_rd = 3'b001;
    waitCmd(seen);
    checkOutput("rst cmd seen", 32'(seen), 32'd1);
    vram_ack = 1'b1;
    @(negedge clock);
    vram_ack = 1'b0;
    req_rd = 3'b000;
    #1;
    checkOutput("rst rdwait busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst async grant_id", 32'(grant_id), 32'd3);
    checkOutput("rst async busy", 32'(busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    vram_rvalid = 1'b1;
    vram_rdata = 32'hFEEDFACE;
    @(negedge clock);
    vram_rvalid = 1'b0;
    #1;
    checkOutput("rst no rvalid", 32'(req_rvalid), 32'd0);
    checkOutput("rst grant_id", 32'(grant_id), 32'd3);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst rdata", req_rdata, 32'h0);
    @(negedge clock);
    #1;
    checkOutput("rst no rvalid later", 32'(req_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
